// File: rtl/apb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_arbiter
// Brief    : Two-master, one-target APB arbiter, round-robin, held per
//            transaction. Optional watchdog: define APB_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module apb_master_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_WIDTH  = 8
) (
    input  logic        clk,
    input  logic        clk__enable,
    input  logic        reset,
    input  logic [31:0] m0_apb_request__paddr,
    input  logic        m0_apb_request__penable,
    input  logic        m0_apb_request__psel,
    input  logic        m0_apb_request__pwrite,
    input  logic [31:0] m0_apb_request__pwdata,
    output logic [31:0] m0_apb_response__prdata,
    output logic        m0_apb_response__pready,
    output logic        m0_apb_response__perr,
    input  logic [31:0] m1_apb_request__paddr,
    input  logic        m1_apb_request__penable,
    input  logic        m1_apb_request__psel,
    input  logic        m1_apb_request__pwrite,
    input  logic [31:0] m1_apb_request__pwdata,
    output logic [31:0] m1_apb_response__prdata,
    output logic        m1_apb_response__pready,
    output logic        m1_apb_response__perr,
    output logic [31:0] apb_request__paddr,
    output logic        apb_request__penable,
    output logic        apb_request__psel,
    output logic        apb_request__pwrite,
    output logic [31:0] apb_request__pwdata,
    input  logic [31:0] apb_response__prdata,
    input  logic        apb_response__pready,
    input  logic        apb_response__perr,
    output logic [1:0]  grant
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_setup  = 2'd1;
    localparam logic [1:0] c_st_access = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic        r_owner;
    logic        r_last_owner;
    logic        r_grant_valid;
    logic        w_req0;
    logic        w_req1;
    logic        w_winner;
    logic        w_take;
    logic        w_target_done;
    logic        w_timeout;
    logic        w_complete;
    logic        w_resp_valid;
    logic        w_resp_perr;
    logic [31:0] w_resp_prdata;
    logic        w_unused_penable;

    // The arbiter regenerates the access phase itself, so master penable is ignored.
    assign w_unused_penable = m0_apb_request__penable ^ m1_apb_request__penable;

    if (TIMEOUT_CYCLES >= (2 ** TIMEOUT_WIDTH)) begin : g_bad_timeout_cfg
        $error("apb_master_arbiter: TIMEOUT_CYCLES must be below 2**TIMEOUT_WIDTH");
    end

    assign w_req0        = m0_apb_request__psel;
    assign w_req1        = m1_apb_request__psel;
    assign w_winner      = (w_req0 && w_req1) ? ~r_last_owner : w_req1;
    assign w_take        = (r_state == c_st_idle) && (w_req0 || w_req1);
    assign w_target_done = (r_state == c_st_access) && apb_response__pready;
    assign w_complete    = w_target_done || w_timeout;

`ifdef APB_ARB_TIMEOUT_EN
    localparam logic [TIMEOUT_WIDTH-1:0] c_timeout = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);

    logic [TIMEOUT_WIDTH-1:0] r_timeout_cnt;

    always_ff @(posedge clk) begin
        if (clk__enable) begin
            if (reset || w_take) begin
                r_timeout_cnt <= '0;
            end else if ((r_state == c_st_access) && !apb_response__pready) begin
                r_timeout_cnt <= r_timeout_cnt + 1'b1;
            end
        end
    end

    // A target pready in the same cycle wins over the forced error completion.
    assign w_timeout = (r_state == c_st_access) && !apb_response__pready &&
                       (r_timeout_cnt == c_timeout);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (clk__enable) begin
            if (reset) begin
                r_state       <= c_st_idle;
                r_owner       <= 1'b0;
                r_last_owner  <= 1'b1;
                r_grant_valid <= 1'b0;
            end else begin
                r_state       <= w_state_next;
                r_grant_valid <= (w_state_next != c_st_idle);
                if (w_take) begin
                    r_owner      <= w_winner;
                    r_last_owner <= w_winner;
                end
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:   if (w_take) w_state_next = c_st_setup;
            c_st_setup:  w_state_next = c_st_access;
            c_st_access: if (w_complete) w_state_next = c_st_idle;
            default:     w_state_next = c_st_idle;
        endcase
    end

    always_comb begin
        apb_request__psel    = (r_state == c_st_setup) || (r_state == c_st_access);
        apb_request__penable = (r_state == c_st_access);
        apb_request__paddr   = r_owner ? m1_apb_request__paddr  : m0_apb_request__paddr;
        apb_request__pwrite  = r_owner ? m1_apb_request__pwrite : m0_apb_request__pwrite;
        apb_request__pwdata  = r_owner ? m1_apb_request__pwdata : m0_apb_request__pwdata;

        // Reset abandons an in-flight transfer without answering its owner.
        w_resp_valid  = w_complete && !reset;
        w_resp_prdata = w_target_done ? apb_response__prdata : 32'd0;
        w_resp_perr   = w_target_done ? apb_response__perr : w_timeout;

        m0_apb_response__pready = w_resp_valid && !r_owner;
        m0_apb_response__perr   = m0_apb_response__pready && w_resp_perr;
        m0_apb_response__prdata = m0_apb_response__pready ? w_resp_prdata : 32'd0;
        m1_apb_response__pready = w_resp_valid && r_owner;
        m1_apb_response__perr   = m1_apb_response__pready && w_resp_perr;
        m1_apb_response__prdata = m1_apb_response__pready ? w_resp_prdata : 32'd0;

        grant = r_grant_valid ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_master_arbiter.sv
`default_nettype none
// Bench for apb_master_arbiter: vector table for the single-transaction cases,
// scoreboard-checked round-robin burst, and stall / watchdog sequence.
module tb_apb_master_arbiter;

    localparam int          TO = 7;
    localparam logic [31:0] A0 = 32'h1000_0004;
    localparam logic [31:0] A1 = 32'h0000_0008;
    localparam logic [31:0] W1 = 32'h0000_0055;

    logic        clk = 1'b0;
    logic        clk__enable;
    logic        reset;
    logic [31:0] m0_apb_request__paddr, m0_apb_request__pwdata;
    logic        m0_apb_request__penable, m0_apb_request__psel, m0_apb_request__pwrite;
    logic [31:0] m0_apb_response__prdata;
    logic        m0_apb_response__pready, m0_apb_response__perr;
    logic [31:0] m1_apb_request__paddr, m1_apb_request__pwdata;
    logic        m1_apb_request__penable, m1_apb_request__psel, m1_apb_request__pwrite;
    logic [31:0] m1_apb_response__prdata;
    logic        m1_apb_response__pready, m1_apb_response__perr;
    logic [31:0] apb_request__paddr, apb_request__pwdata;
    logic        apb_request__penable, apb_request__psel, apb_request__pwrite;
    logic [31:0] apb_response__prdata;
    logic        apb_response__pready, apb_response__perr;
    logic [1:0]  grant;

    int total = 0;
    int bad   = 0;

    apb_master_arbiter #(.TIMEOUT_CYCLES(TO), .TIMEOUT_WIDTH(8)) dut (
        .clk(clk), .clk__enable(clk__enable), .reset(reset),
        .m0_apb_request__paddr(m0_apb_request__paddr), .m0_apb_request__penable(m0_apb_request__penable),
        .m0_apb_request__psel(m0_apb_request__psel), .m0_apb_request__pwrite(m0_apb_request__pwrite),
        .m0_apb_request__pwdata(m0_apb_request__pwdata),
        .m0_apb_response__prdata(m0_apb_response__prdata), .m0_apb_response__pready(m0_apb_response__pready),
        .m0_apb_response__perr(m0_apb_response__perr),
        .m1_apb_request__paddr(m1_apb_request__paddr), .m1_apb_request__penable(m1_apb_request__penable),
        .m1_apb_request__psel(m1_apb_request__psel), .m1_apb_request__pwrite(m1_apb_request__pwrite),
        .m1_apb_request__pwdata(m1_apb_request__pwdata),
        .m1_apb_response__prdata(m1_apb_response__prdata), .m1_apb_response__pready(m1_apb_response__pready),
        .m1_apb_response__perr(m1_apb_response__perr),
        .apb_request__paddr(apb_request__paddr), .apb_request__penable(apb_request__penable),
        .apb_request__psel(apb_request__psel), .apb_request__pwrite(apb_request__pwrite),
        .apb_request__pwdata(apb_request__pwdata),
        .apb_response__prdata(apb_response__prdata), .apb_response__pready(apb_response__pready),
        .apb_response__perr(apb_response__perr),
        .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_g(input string name, input logic [1:0] act, input logic [1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // rst,s0,s1,trdy,terr inputs; psel,penable,pwrite + bus/response expectations
    typedef struct {
        logic        rst, s0, s1, trdy, terr;
        logic [31:0] trdata;
        logic        psel, pen, pwrite;
        logic [31:0] paddr, pwdata;
        logic [1:0]  rdy, err, gnt;
        logic [31:0] rd0, rd1;
    } vec_t;

    function automatic vec_t mk(input logic [4:0] ib, input logic [31:0] trd, input logic [2:0] ob,
                                input logic [31:0] pa, input logic [31:0] pw,
                                input logic [1:0] rdy, input logic [1:0] err, input logic [1:0] gnt,
                                input logic [31:0] rd0, input logic [31:0] rd1);
        vec_t v;
        {v.rst, v.s0, v.s1, v.trdy, v.terr} = ib;
        v.trdata = trd;
        {v.psel, v.pen, v.pwrite} = ob;
        v.paddr = pa;  v.pwdata = pw;
        v.rdy = rdy;   v.err = err;   v.gnt = gnt;
        v.rd0 = rd0;   v.rd1 = rd1;
        return v;
    endfunction

    typedef struct {
        logic [31:0] paddr;
        logic [31:0] pwdata;
    } req_t;

    vec_t vecs[25];
    vec_t exp_q[$];
    req_t q0[$];
    req_t q1[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t e;
        req_t r;
        int   cnt0, cnt1, push0, push1, n_setup;
        logic [31:0] xa, xd;

        clk__enable = 1'b1;
        reset = 1'b1;
        m0_apb_request__paddr = A0; m0_apb_request__pwrite = 1'b0; m0_apb_request__pwdata = 32'd0;
        m1_apb_request__paddr = A1; m1_apb_request__pwrite = 1'b1; m1_apb_request__pwdata = W1;
        m0_apb_request__psel = 1'b0; m1_apb_request__psel = 1'b0;
        m0_apb_request__penable = 1'b0; m1_apb_request__penable = 1'b0;
        apb_response__pready = 1'b0; apb_response__perr = 1'b0; apb_response__prdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // reset, single read, simultaneous request, 5-wait error, reset mid-ACCESS
        vecs[0]  = mk(5'b10000, 32'd0,         3'b000, 32'd0, 32'd0, 2'b00, 2'b00, 2'b00, 32'd0, 32'd0);
        vecs[1]  = mk(5'b01000, 32'd0,         3'b000, 32'd0, 32'd0, 2'b00, 2'b00, 2'b00, 32'd0, 32'd0);
        vecs[2]  = mk(5'b01000, 32'd0,         3'b100, A0,    32'd0, 2'b00, 2'b00, 2'b01, 32'd0, 32'd0);
        vecs[3]  = mk(5'b01010, 32'hDEAD_BEEF, 3'b110, A0,    32'd0, 2'b01, 2'b00, 2'b01, 32'hDEAD_BEEF, 32'd0);
        vecs[4]  = mk(5'b00000, 32'd0,         3'b000, 32'd0, 32'd0, 2'b00, 2'b00, 2'b00, 32'd0, 32'd0);
        vecs[5]  = mk(5'b10000, 32'd0,         3'b000, 32'd0, 32'd0, 2'b00, 2'b00, 2'b00, 32'd0, 32'd0);
        vecs[6]  = mk(5'b01100, 32'd0,         3'b000, 32'd0, 32'd0, 2'b00, 2'b00, 2'b00, 32'd0, 32'd0);
        vecs[7]  = mk(5'b01100, 32'd0,         3'b100, A0,    32'd0, 2'b00, 2'b00, 2'b01, 32'd0, 32'd0);
        vecs[8]  = mk(5'b01110, 32'h0000_1234, 3'b110, A0,    32'd0, 2'b01, 2'b00, 2'b01, 32'h0000_1234, 32'd0);
        vecs[9]  = mk(5'b00100, 32'd0,         3'b000, 32'd0, 32'd0, 2'b00, 2'b00, 2'b00, 32'd0, 32'd0);
        vecs[10] = mk(5'b00100, 32'd0,         3'b101, A1,    W1,    2'b00, 2'b00, 2'b10, 32'd0, 32'd0);
        for (int i = 11; i <= 15; i++)
            vecs[i] = mk(5'b00100, 32'hCAFE_0000, 3'b111, A1, W1, 2'b00, 2'b00, 2'b10, 32'd0, 32'd0);
        vecs[16] = mk(5'b00111, 32'h0000_0077, 3'b111, A1,    W1,    2'b10, 2'b10, 2'b10, 32'd0, 32'h0000_0077);
        vecs[17] = mk(5'b00000, 32'd0,         3'b000, 32'd0, 32'd0, 2'b00, 2'b00, 2'b00, 32'd0, 32'd0);
        vecs[18] = mk(5'b01000, 32'd0,         3'b000, 32'd0, 32'd0, 2'b00, 2'b00, 2'b00, 32'd0, 32'd0);
        vecs[19] = mk(5'b01000, 32'd0,         3'b100, A0,    32'd0, 2'b00, 2'b00, 2'b01, 32'd0, 32'd0);
        vecs[20] = mk(5'b11000, 32'd0,         3'b110, A0,    32'd0, 2'b00, 2'b00, 2'b01, 32'd0, 32'd0);
        vecs[21] = mk(5'b01100, 32'd0,         3'b000, 32'd0, 32'd0, 2'b00, 2'b00, 2'b00, 32'd0, 32'd0);
        vecs[22] = mk(5'b01100, 32'd0,         3'b100, A0,    32'd0, 2'b00, 2'b00, 2'b01, 32'd0, 32'd0);
        vecs[23] = mk(5'b01110, 32'h0000_00A5, 3'b110, A0,    32'd0, 2'b01, 2'b00, 2'b01, 32'h0000_00A5, 32'd0);
        vecs[24] = mk(5'b00000, 32'd0,         3'b000, 32'd0, 32'd0, 2'b00, 2'b00, 2'b00, 32'd0, 32'd0);

        for (int i = 0; i < 25; i++) begin
            reset                = vecs[i].rst;
            m0_apb_request__psel = vecs[i].s0;
            m1_apb_request__psel = vecs[i].s1;
            apb_response__pready = vecs[i].trdy;
            apb_response__perr   = vecs[i].terr;
            apb_response__prdata = vecs[i].trdata;
            exp_q.push_back(vecs[i]);
            #1;
            e = exp_q.pop_front();
            chk_b($sformatf("v%0d_psel", i), apb_request__psel, e.psel);
            chk_b($sformatf("v%0d_penable", i), apb_request__penable, e.pen);
            chk_g($sformatf("v%0d_grant", i), grant, e.gnt);
            chk_g($sformatf("v%0d_pready", i), {m1_apb_response__pready, m0_apb_response__pready}, e.rdy);
            chk_g($sformatf("v%0d_perr", i), {m1_apb_response__perr, m0_apb_response__perr}, e.err);
            chk_w($sformatf("v%0d_prdata0", i), m0_apb_response__prdata, e.rd0);
            chk_w($sformatf("v%0d_prdata1", i), m1_apb_response__prdata, e.rd1);
            if (e.psel) begin
                chk_w($sformatf("v%0d_paddr", i), apb_request__paddr, e.paddr);
                chk_w($sformatf("v%0d_pwdata", i), apb_request__pwdata, e.pwdata);
                chk_b($sformatf("v%0d_pwrite", i), apb_request__pwrite, e.pwrite);
            end
            step();
        end

        // Round-robin burst: 4 writes per master, owners must alternate from m0.
        reset = 1'b1;
        m0_apb_request__psel = 1'b0; m1_apb_request__psel = 1'b0;
        m0_apb_request__pwrite = 1'b1;
        step();
        reset = 1'b0;
        cnt0 = 0; cnt1 = 0; push0 = 0; push1 = 0; n_setup = 0;
        for (int cyc = 0; cyc < 300 && (cnt0 < 4 || cnt1 < 4); cyc++) begin
            m0_apb_request__psel   = (cnt0 < 4);
            m0_apb_request__paddr  = 32'h2000_0000 + 32'(cnt0 * 4);
            m0_apb_request__pwdata = 32'hA000_0000 + 32'(cnt0);
            m1_apb_request__psel   = (cnt1 < 4);
            m1_apb_request__paddr  = 32'h3000_0000 + 32'(cnt1 * 4);
            m1_apb_request__pwdata = 32'hB000_0000 + 32'(cnt1);
            if (cnt0 < 4 && push0 == cnt0) begin
                q0.push_back('{m0_apb_request__paddr, m0_apb_request__pwdata});
                push0++;
            end
            if (cnt1 < 4 && push1 == cnt1) begin
                q1.push_back('{m1_apb_request__paddr, m1_apb_request__pwdata});
                push1++;
            end
            apb_response__pready = 1'($urandom_range(0, 1));
            apb_response__perr   = 1'b0;
            #1;
            if (apb_request__psel && !apb_request__penable) begin
                if ((n_setup % 2) == 0) begin
                    xa = 32'hFFFF_FFFF; xd = 32'hFFFF_FFFF;
                    if (q0.size() > 0) begin r = q0.pop_front(); xa = r.paddr; xd = r.pwdata; end
                    chk_g($sformatf("rr%0d_grant", n_setup), grant, 2'b01);
                end else begin
                    xa = 32'hFFFF_FFFF; xd = 32'hFFFF_FFFF;
                    if (q1.size() > 0) begin r = q1.pop_front(); xa = r.paddr; xd = r.pwdata; end
                    chk_g($sformatf("rr%0d_grant", n_setup), grant, 2'b10);
                end
                chk_w($sformatf("rr%0d_paddr", n_setup), apb_request__paddr, xa);
                chk_w($sformatf("rr%0d_pwdata", n_setup), apb_request__pwdata, xd);
                chk_b($sformatf("rr%0d_pwrite", n_setup), apb_request__pwrite, 1'b1);
                n_setup++;
            end
            chk_b("rr_pready_exclusive", m0_apb_response__pready & m1_apb_response__pready, 1'b0);
            if (m0_apb_response__pready) cnt0++;
            if (m1_apb_response__pready) cnt1++;
            step();
        end
        chk_w("rr_m0_done", 32'(cnt0), 32'd4);
        chk_w("rr_m1_done", 32'(cnt1), 32'd4);
        chk_w("rr_setups", 32'(n_setup), 32'd8);

        // Clock enable freezes arbitration; then a target that never answers.
        m0_apb_request__psel = 1'b0; m1_apb_request__psel = 1'b0;
        m0_apb_request__paddr = A0; m0_apb_request__pwrite = 1'b0;
        apb_response__pready = 1'b0; apb_response__prdata = 32'hFFFF_FFFF;
        reset = 1'b1;
        step();
        reset = 1'b0;
        m0_apb_request__psel = 1'b1;
        clk__enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_b("cke_hold_psel", apb_request__psel, 1'b0);
            step();
        end
        clk__enable = 1'b1;
        #1;
        chk_b("cke_idle_psel", apb_request__psel, 1'b0);
        step();
        #1;
        chk_b("cke_setup_psel", apb_request__psel, 1'b1);
        chk_b("cke_setup_penable", apb_request__penable, 1'b0);
        step();
`ifdef APB_ARB_TIMEOUT_EN
        for (int i = 1; i <= TO + 1; i++) begin
            #1;
            chk_b($sformatf("to%0d_psel", i), apb_request__psel, 1'b1);
            chk_b($sformatf("to%0d_pready", i), m0_apb_response__pready, (i == TO + 1));
            chk_b($sformatf("to%0d_perr", i), m0_apb_response__perr, (i == TO + 1));
            chk_w($sformatf("to%0d_prdata", i), m0_apb_response__prdata, 32'd0);
            step();
        end
        m0_apb_request__psel = 1'b0;
        #1;
        chk_b("to_idle_psel", apb_request__psel, 1'b0);
`else
        for (int i = 1; i <= 120; i++) begin
            #1;
            chk_b("stall_pready", m0_apb_response__pready, 1'b0);
            chk_b("stall_penable", apb_request__penable, 1'b1);
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        m0_apb_request__psel = 1'b0;
        #1;
        chk_b("stall_reset_psel", apb_request__psel, 1'b0);
`endif
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Two-master, one-target APB arbiter that shares a single APB target bus, e.g. the timer/GPIO decode fabric, between the apb_processor and a second master such as a debug or host bridge.
- Arbitration is round-robin and held for a whole transaction.
- The block replays the APB setup/access phases on the target side and stalls the losing master with pready low.
- It sits between the masters' apb_request/apb_response buses and the target-side address decode.

Parameters:
- TIMEOUT_CYCLES, 255: number of ACCESS-state cycles without target pready before a forced error completion. Used only with APB_ARB_TIMEOUT_EN.
- TIMEOUT_WIDTH, 8: width of the timeout counter. Must satisfy TIMEOUT_CYCLES < 2^TIMEOUT_WIDTH.

Ports:
- clk, in, 1: system clock.
- clk__enable, in, 1: clock enable; all state advances only when high.
- reset, in, 1: synchronous, active-high reset.
- m0_apb_request__paddr/penable/psel/pwrite/pwdata, in, 32/1/1/1/32: master 0 request (higher priority on first arbitration after reset).
- m0_apb_response__prdata/pready/perr, out, 32/1/1: master 0 response.
- m1_apb_request__paddr/penable/psel/pwrite/pwdata, in, 32/1/1/1/32: master 1 request.
- m1_apb_response__prdata/pready/perr, out, 32/1/1: master 1 response.
- apb_request__paddr/penable/psel/pwrite/pwdata, out, 32/1/1/1/32: target-side request.
- apb_response__prdata/pready/perr, in, 32/1/1: target-side response.
- grant, out, 2: one-hot current owner, 2'b00 when idle.

Behaviour:
- Registered state: fsm (IDLE, SETUP, ACCESS), owner (1 bit), last_owner (1 bit), grant_valid. With APB_ARB_TIMEOUT_EN, also timeout counter.
- Reset, synchronous, when reset=1 at a clk edge with clk__enable=1:
  - fsm=IDLE, grant_valid=0, last_owner=1 so master 0 wins first.
  - Outputs during and after reset: target psel=0, penable=0; both m*_pready=0, perr=0, prdata=0; grant=0.
  - Reset mid-transaction abandons it immediately; target psel drops the next cycle. No response is given to the owner.
- IDLE:
  - Requesters are masters with psel=1.
  - None: stay in IDLE.
  - One: grant it.
  - Both: grant !last_owner.
  - On grant: owner<=winner, last_owner<=winner, fsm<=SETUP.
  - Target psel=0 in IDLE.
- SETUP, exactly one cycle:
  - Target psel=1, penable=0.
  - paddr/pwrite/pwdata are driven combinationally from the owner's request.
  - fsm<=ACCESS.
- ACCESS:
  - Target psel=1, penable=1, same mux.
  - When target pready=1: owner's m_pready=1 combinationally, with prdata/perr forwarded from the target. fsm<=IDLE.
  - Otherwise stay in ACCESS.
- Non-owner, and owner outside ACCESS: pready=0, perr=0, prdata=0. This holds a stalled master in its access phase; masters keep paddr/pwdata/pwrite stable while psel=1, per APB.
- Latency: minimum 3 cycles from master psel in IDLE to master pready (IDLE→SETUP→ACCESS with target pready=1 in ACCESS). There is one IDLE cycle between back-to-back transactions.
- Fairness: with both masters continuously requesting, grants strictly alternate 0,1,0,1.
- Owner drops psel mid-transaction (protocol violation): the arbiter still completes the target transaction and returns to IDLE.
- grant = one-hot of owner while fsm != IDLE, else 0.

Optional Feature:
- Macro: APB_ARB_TIMEOUT_EN.
- With the macro defined:
  - The counter clears on SETUP entry and increments each ACCESS cycle without target pready.
  - When counter == TIMEOUT_CYCLES and target pready=0, the owner gets pready=1, perr=1, prdata=0 that cycle, and fsm<=IDLE (target psel drops).
  - Target pready on the same cycle takes precedence: normal completion.
- Without the macro: no counter; ACCESS waits indefinitely for target pready.

Test Plan:
- Reset, then m0 reads paddr=0x1000_0004 and the target returns prdata=0xDEAD_BEEF with pready on the first ACCESS cycle -> target psel rises at cycle 1, penable at cycle 2; m0 pready=1 with prdata=0xDEAD_BEEF at cycle 2; grant=2'b01 for cycles 1-2; m1 pready stays 0.
- m0 and m1 assert psel the same cycle after reset -> m0 served first. m1 sees pready=0 throughout m0's transaction, then is granted after one IDLE cycle; its target SETUP phase shows m1's paddr=0x0000_0008 and pwdata=0x55.
- Both masters issue 4 back-to-back writes each -> target sees owners 0,1,0,1,0,1,0,1; every transaction has one SETUP cycle with penable=0.
- Target holds pready=0 for 5 ACCESS cycles, then returns perr=1 -> owner pready=1, perr=1 exactly on the 6th ACCESS cycle; target psel stays 1 throughout.
- Reset asserted during ACCESS -> next cycle target psel=0, penable=0, grant=0. After release, m0 wins the first arbitration even if m0 was the interrupted owner.
- With APB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=3, target never asserts pready -> owner gets pready=1, perr=1, prdata=0 on the 4th ACCESS cycle; fsm returns to IDLE. Without the macro, it stalls for 100+ cycles with no pready.
